pwm_duty_button_conditioner: RTL
================================

PWM_DUTY_BUTTON_CONDITIONER -- requirements
Module: pwm_duty_button_conditioner

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is clk, and the reset is rst_n, asynchronous and active-low.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: number of consecutive stable synchronized samples that accept a press or a release; legal range 2..65535.
REQ-003 Parameter REPEAT_DELAY, default 250000: cycles from press acceptance to the first auto-repeat pulse; legal minimum 2.
REQ-004 Parameter REPEAT_PERIOD, default 50000: cycles between successive auto-repeat pulses; legal minimum 2.
REQ-005 Port clk  input  1: system clock.
REQ-006 Port rst_n  input  1: asynchronous active-low reset.
REQ-007 Port ena  input  1: block enable, high while the design is selected.
REQ-008 Port btn_inc_raw  input  1: asynchronous, bouncy increase-duty button, active-high.
REQ-009 Port btn_dec_raw  input  1: asynchronous, bouncy decrease-duty button, active-high.
REQ-010 Port inc_pulse  output  1: one-cycle request to the PWM generator to increase duty.
REQ-011 Port dec_pulse  output  1: one-cycle request to the PWM generator to decrease duty.
REQ-012 Port inc_held  output  1: the increase button is in an accepted-pressed state.
REQ-013 Port dec_held  output  1: the decrease button is in an accepted-pressed state.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer; all logic downstream of the synchronizer SHALL use only the synchronized value.
REQ-015 Each button SHALL have an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, and its own counter that is at least 16 bits wide and saturates rather than wrapping.
REQ-016 IDLE -> PRESS_WAIT when the synchronized input is 1; the counter clears to 0 on this transition.
REQ-017 PRESS_WAIT -> IDLE on any synchronized 0; PRESS_WAIT -> HELD after DEBOUNCE_CYCLES consecutive synchronized 1 samples.
REQ-018 HELD -> RELEASE_WAIT on a synchronized 0; the counter clears to 0 on this transition.
REQ-019 RELEASE_WAIT -> HELD on any synchronized 1, with no pulse; RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive synchronized 0 samples.
REQ-020 A pulse SHALL be registered and high for exactly one cycle, the first cycle the FSM is in HELD; latency is DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw input high, given a stable input.
REQ-021 The x_held outputs SHALL be registered and high while their FSM is in HELD or RELEASE_WAIT.
REQ-022 If inc_pulse and dec_pulse would assert in the same cycle, both SHALL be suppressed; both FSMs still advance to HELD.
REQ-023 While one button is held, any pulse from the other button SHALL be suppressed; the other button's FSM still tracks its input.
REQ-024 When ena is 0, both FSMs SHALL be forced to IDLE, counters cleared, and all outputs 0; synchronizers keep running.

Reset
REQ-025 When rst_n is low, the block SHALL immediately clear the synchronizers, counters and all outputs to 0 and put both FSMs in IDLE, regardless of clk.
REQ-026 After reset release with a button already high, that button SHALL run a full debounce before it pulses; no pulse SHALL be produced on reset exit itself.

Configuration
REQ-027 Macro PWM_BTN_AUTO_REPEAT_EN defined: while in HELD, a repeat pulse SHALL fire REPEAT_DELAY cycles after the acceptance pulse and then every REPEAT_PERIOD cycles.
REQ-028 In RELEASE_WAIT, the repeat timing SHALL pause; returning to HELD SHALL resume the timing without reset.
REQ-029 Repeat pulses SHALL obey REQ-022 and REQ-023.
REQ-030 Macro undefined: the repeat counters SHALL not be present, and the block SHALL produce exactly one pulse per accepted press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3; btn_inc_raw rises at edge 0)
REQ-031 Clean press: btn_inc_raw high for 20 cycles -> inc_pulse high only at edge 7; inc_held high from edge 7; dec_pulse stays 0.
REQ-032 Bounce: btn_inc_raw 1,1,0 at edges 0-2, then stable 1 -> exactly one inc_pulse, at edge 10.
REQ-033 Both buttons raised at edge 0 -> no pulses; inc_held and dec_held both high at edge 7.
REQ-034 Release glitch: during HELD, btn_inc_raw low for 2 cycles, then high -> no new pulse; inc_held never drops.
REQ-035 Reset: rst_n low at edge 5 with btn_inc_raw held high, released at edge 9 -> outputs 0 during reset; inc_pulse at edge 16.
REQ-036 Auto-repeat: with PWM_BTN_AUTO_REPEAT_EN defined, btn_inc_raw held for 30 cycles -> inc_pulse at edges 7, 15, 18, 21, 24, 27, 30; without the macro, only at edge 7.

Source files
------------

// File: rtl/pwm_duty_button_conditioner.sv
// pwm_duty_button_conditioner: debounces two bouncy push-buttons (increase /
// decrease duty) into one-cycle requests for a PWM generator, plus held flags.
// Optional auto-repeat while a button stays pressed: define
// PWM_BTN_AUTO_REPEAT_EN to enable it. Default build: one pulse per press.

// Per-button lane: synchronizer, debounce FSM, optional repeat timer.
module pwm_duty_button_lane #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 250000,
  parameter int REPEAT_PERIOD   = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic i_raw,
  output logic o_req,   // registered request, one cycle, before arbitration
  output logic o_busy,  // FSM in HELD or RELEASE_WAIT (for cross suppression)
  output logic o_held   // registered held flag
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} st_t;

  localparam logic [15:0] DB_M1 = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  r_sync;
  logic        w_sync;
  st_t         r_st, w_st_nxt;
  logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        w_acc;
  logic        w_rep_fire;
  logic        r_req, r_held;

  assign w_sync = r_sync[1];

  // Two-flop synchronizer; keeps running while the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_raw};
  end

  // Debounce FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic; w_acc marks the PRESS_WAIT -> HELD acceptance edge.
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    w_acc     = 1'b0;
    w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    case (r_st)
      IDLE: begin
        if (w_sync) begin
          w_st_nxt  = PRESS_WAIT;
          w_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_sync) w_st_nxt = IDLE;
        else if (r_cnt == DB_M1) begin
          w_st_nxt = HELD;
          w_acc    = 1'b1;
        end else w_cnt_nxt = w_cnt_inc;
      end
      HELD: begin
        if (!w_sync) begin
          w_st_nxt  = RELEASE_WAIT;
          w_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_sync) w_st_nxt = HELD;
        else if (r_cnt == DB_M1) w_st_nxt = IDLE;
        else w_cnt_nxt = w_cnt_inc;
      end
      default: w_st_nxt = IDLE;
    endcase
    if (!ena) begin
      w_st_nxt  = IDLE;
      w_cnt_nxt = '0;
      w_acc     = 1'b0;
    end
  end

`ifdef PWM_BTN_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] RD_M1 = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_M1 = RCW'(REPEAT_PERIOD - 1);

  logic [RCW-1:0] r_rep;
  logic           r_phase;  // 0: waiting first delay, 1: periodic
  logic [RCW-1:0] w_target;

  assign w_target   = r_phase ? RP_M1 : RD_M1;
  assign w_rep_fire = ena && (r_st == HELD) && (r_rep == w_target);

  // Repeat timer: restarts on acceptance, advances only in HELD, so it
  // pauses through RELEASE_WAIT and resumes where it left off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep   <= '0;
      r_phase <= 1'b0;
    end else if (!ena || w_acc) begin
      r_rep   <= '0;
      r_phase <= 1'b0;
    end else if (r_st == HELD) begin
      if (r_rep == w_target) begin
        r_rep   <= '0;
        r_phase <= 1'b1;
      end else r_rep <= r_rep + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Registered request and held flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= 1'b0;
      r_held <= 1'b0;
    end else begin
      r_req  <= ena & (w_acc | w_rep_fire);
      r_held <= ena & ((r_st == HELD) | (r_st == RELEASE_WAIT));
    end
  end

  assign o_req  = r_req;
  assign o_busy = (r_st == HELD) || (r_st == RELEASE_WAIT);
  assign o_held = r_held;
endmodule

// Top: two lanes plus pulse arbitration.
module pwm_duty_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 250000,
  parameter int REPEAT_PERIOD   = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_held,
  output logic dec_held
);
  logic [1:0] w_raw, w_req, w_busy, w_held;

  assign w_raw = {btn_dec_raw, btn_inc_raw};

  // Lane 0 = increase, lane 1 = decrease.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    pwm_duty_button_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .i_raw (w_raw[g]),
      .o_req (w_req[g]),
      .o_busy(w_busy[g]),
      .o_held(w_held[g])
    );
  end

  logic r_inc_pulse, r_dec_pulse;

  // Arbitrate: simultaneous requests cancel; a held button blocks the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc_pulse <= 1'b0;
      r_dec_pulse <= 1'b0;
    end else begin
      r_inc_pulse <= ena & w_req[0] & ~w_req[1] & ~w_busy[1];
      r_dec_pulse <= ena & w_req[1] & ~w_req[0] & ~w_busy[0];
    end
  end

  assign inc_pulse = r_inc_pulse;
  assign dec_pulse = r_dec_pulse;
  assign inc_held  = w_held[0];
  assign dec_held  = w_held[1];
endmodule
